// File: rtl/libhdl_stream_downsizer.sv
// Wide-to-narrow stream converter: accepts one IN_LEN word per handshake and
// replays it as RATIO OUT_LEN beats, back-to-back across words when possible.
module libhdl_stream_downsizer #(
    parameter int unsigned IN_LEN    = 32,
    parameter int unsigned OUT_LEN   = 8,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    output logic                               o_irdy,
    input  logic                               i_ivld,
    input  logic [IN_LEN-1:0]                  i_idat,
    input  logic                               i_ilast,
    input  logic                               i_ordy,
    output logic                               o_ovld,
    output logic [OUT_LEN-1:0]                 o_odat,
    output logic                               o_olast,
    output logic [$clog2(IN_LEN/OUT_LEN)-1:0]  o_oidx,
    output logic                               o_busy
);

    localparam int unsigned        RATIO    = IN_LEN / OUT_LEN;
    localparam int unsigned        IDX_W    = $clog2(RATIO);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(RATIO - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                        state_q, state_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [RATIO-1:0][OUT_LEN-1:0] hold_q, hold_d;
    logic                          last_q, last_d;
    logic                          run_q;
    logic                          at_end;
    logic                          in_hs;
    logic                          out_hs;
    logic [IDX_W-1:0]              sel;

    assign at_end = (idx_q == LAST_IDX);
    assign in_hs  = o_irdy & i_ivld;
    assign out_hs = o_ovld & i_ordy;

    // State register; run_q keeps the upstream ready low until the first edge after reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            hold_q  <= '0;
            last_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
            run_q   <= 1'b1;
        end
    end

    // Next-state: load on accept, step on each beat, reload on the final beat if a word is offered.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (in_hs) begin
                    hold_d  = i_idat;
                    last_d  = i_ilast;
                    idx_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (out_hs) begin
                    if (!at_end) begin
                        idx_d = idx_q + IDX_W'(1);
                    end else if (in_hs) begin
                        hold_d = i_idat;
                        last_d = i_ilast;
                        idx_d  = '0;
                    end else begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: decoded from registered state; only o_irdy looks at i_ordy.
    always_comb begin
        o_irdy  = 1'b0;
        o_ovld  = 1'b0;
        o_odat  = '0;
        o_olast = 1'b0;
        o_oidx  = idx_q;
        o_busy  = 1'b0;
        sel     = MSB_FIRST ? (LAST_IDX - idx_q) : idx_q;
        case (state_q)
            IDLE: begin
                o_irdy = run_q;
            end
            SHIFT: begin
                o_irdy  = run_q & at_end & i_ordy;
                o_ovld  = 1'b1;
                o_odat  = hold_q[sel];
                o_olast = last_q & at_end;
                o_busy  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_libhdl_stream_downsizer.sv
// Directed and randomized checks of the 32->8 stream downsizer in both slice orders.
module tb_libhdl_stream_downsizer;

    logic        clk;
    logic        rst_n;
    logic        ivld;
    logic [31:0] idat;
    logic        ilast;
    logic        ordy;

    logic        irdy, ovld, olast, busy;
    logic [7:0]  odat;
    logic [1:0]  oidx;
    logic        m_irdy, m_ovld, m_olast, m_busy;
    logic [7:0]  m_odat;
    logic [1:0]  m_oidx;

    int n_tests = 0;
    int n_fail  = 0;

    libhdl_stream_downsizer #(.IN_LEN(32), .OUT_LEN(8), .MSB_FIRST(1'b0)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .o_irdy(irdy), .i_ivld(ivld), .i_idat(idat),
        .i_ilast(ilast), .i_ordy(ordy), .o_ovld(ovld), .o_odat(odat),
        .o_olast(olast), .o_oidx(oidx), .o_busy(busy)
    );

    libhdl_stream_downsizer #(.IN_LEN(32), .OUT_LEN(8), .MSB_FIRST(1'b1)) dut_m (
        .i_clk(clk), .i_rst_n(rst_n), .o_irdy(m_irdy), .i_ivld(ivld), .i_idat(idat),
        .i_ilast(ilast), .i_ordy(ordy), .o_ovld(m_ovld), .o_odat(m_odat),
        .o_olast(m_olast), .o_oidx(m_oidx), .o_busy(m_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0; ivld = 1'b0; idat = '0; ilast = 1'b0; ordy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({irdy, ovld, odat, olast, oidx, busy} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_state: irdy=%b ovld=%b odat=%h olast=%b oidx=%0d busy=%b, expected all 0",
                     irdy, ovld, odat, olast, oidx, busy);
        end
        #3 rst_n = 1'b1;
        #1;
        n_tests++;
        if (irdy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_irdy_before_edge: irdy=%b expected 0", irdy);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (irdy !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_irdy_after_edge: irdy=%b busy=%b expected 1 0", irdy, busy);
        end
    endtask

    task automatic test_single();
        logic [31:0] w;
        w = 32'hAABBCCDD;
        ivld = 1'b1; idat = w; ilast = 1'b1; ordy = 1'b1;
        @(posedge clk);
        #1;
        ivld = 1'b0; idat = '0; ilast = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_tests++;
            if (ovld !== 1'b1 || odat !== w[i*8 +: 8] || oidx !== 2'(i) || olast !== (i == 3)
                || irdy !== (i == 3) || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL single_beat%0d: ovld=%b odat=%h oidx=%0d olast=%b irdy=%b busy=%b, expected 1 %h %0d %b %b 1",
                         i, ovld, odat, oidx, olast, irdy, busy, w[i*8 +: 8], i, (i == 3), (i == 3));
            end
            @(posedge clk);
            #1;
        end
        n_tests++;
        if (ovld !== 1'b0 || busy !== 1'b0 || irdy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_idle: ovld=%b busy=%b irdy=%b expected 0 0 1", ovld, busy, irdy);
        end
    endtask

    task automatic test_back_to_back();
        ivld = 1'b1; idat = 32'h03020100; ilast = 1'b0; ordy = 1'b1;
        @(posedge clk);
        #1;
        idat = 32'h07060504;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) ivld = 1'b0;
            #1;
            n_tests++;
            if (ovld !== 1'b1 || odat !== 8'(i) || oidx !== 2'(i % 4) || olast !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_beat%0d: ovld=%b odat=%h oidx=%0d olast=%b, expected 1 %h %0d 0",
                         i, ovld, odat, oidx, olast, 8'(i), i % 4);
            end
            if (i == 3) begin
                n_tests++;
                if (irdy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_reload_irdy: irdy=%b expected 1", irdy);
                end
            end
            @(posedge clk);
            #1;
        end
        n_tests++;
        if (ovld !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: ovld=%b expected 0", ovld);
        end
    endtask

    task automatic test_backpressure();
        ivld = 1'b1; idat = 32'hAABBCCDD; ilast = 1'b0; ordy = 1'b1;
        @(posedge clk);
        #1;
        ivld = 1'b0;
        #1;
        n_tests++;
        if (ovld !== 1'b1 || odat !== 8'hDD) begin
            n_fail++;
            $display("FAIL bp_first: ovld=%b odat=%h expected 1 dd", ovld, odat);
        end
        @(posedge clk);
        #1;
        ordy = 1'b0;
        ivld = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_tests++;
            if (ovld !== 1'b1 || odat !== 8'hCC || oidx !== 2'd1 || irdy !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: ovld=%b odat=%h oidx=%0d irdy=%b expected 1 cc 1 0",
                         k, ovld, odat, oidx, irdy);
            end
            @(posedge clk);
            #1;
        end
        ordy = 1'b1;
        ivld = 1'b0;
        for (int i = 1; i < 4; i++) begin
            #1;
            n_tests++;
            if (ovld !== 1'b1 || odat !== 8'(32'hAABBCCDD >> (i * 8)) || oidx !== 2'(i)) begin
                n_fail++;
                $display("FAIL bp_resume%0d: ovld=%b odat=%h oidx=%0d expected 1 %h %0d",
                         i, ovld, odat, oidx, 8'(32'hAABBCCDD >> (i * 8)), i);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_msb_first();
        logic [31:0] w;
        w = 32'h11223344;
        ivld = 1'b1; idat = w; ilast = 1'b1; ordy = 1'b1;
        @(posedge clk);
        #1;
        ivld = 1'b0; ilast = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_tests++;
            if (m_ovld !== 1'b1 || m_odat !== w[(3-i)*8 +: 8] || m_oidx !== 2'(i) || m_olast !== (i == 3)) begin
                n_fail++;
                $display("FAIL msb_beat%0d: ovld=%b odat=%h oidx=%0d olast=%b, expected 1 %h %0d %b",
                         i, m_ovld, m_odat, m_oidx, m_olast, w[(3-i)*8 +: 8], i, (i == 3));
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid_word();
        logic [31:0] w;
        ivld = 1'b1; idat = 32'hAABBCCDD; ilast = 1'b1; ordy = 1'b1;
        @(posedge clk);
        #1;
        ivld = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if (odat !== 8'hCC || oidx !== 2'd1) begin
            n_fail++;
            $display("FAIL rstmid_pre: odat=%h oidx=%0d expected cc 1", odat, oidx);
        end
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({irdy, ovld, odat, olast, oidx, busy} !== 13'h0) begin
            n_fail++;
            $display("FAIL rstmid_async: irdy=%b ovld=%b odat=%h olast=%b oidx=%0d busy=%b, expected all 0",
                     irdy, ovld, odat, olast, oidx, busy);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (irdy !== 1'b1 || ovld !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_release: irdy=%b ovld=%b expected 1 0", irdy, ovld);
        end
        w = 32'h44332211;
        ivld = 1'b1; idat = w; ilast = 1'b0;
        @(posedge clk);
        #1;
        ivld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_tests++;
            if (ovld !== 1'b1 || odat !== w[i*8 +: 8] || oidx !== 2'(i) || olast !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_beat%0d: ovld=%b odat=%h oidx=%0d olast=%b, expected 1 %h %0d 0",
                         i, ovld, odat, oidx, olast, w[i*8 +: 8], i);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_random();
        logic [10:0] q[$];
        logic        accepted;
        logic        ihs, ohs;
        int          ilast_cnt, olast_cnt;
        accepted = 1'b1; ilast_cnt = 0; olast_cnt = 0;
        ivld = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            if (!ivld || accepted) begin
                ivld  = 1'($urandom_range(0, 1));
                idat  = $urandom;
                ilast = 1'($urandom_range(0, 1));
            end
            ordy = ($urandom_range(0, 3) != 0);
            #1;
            ihs = irdy & ivld;
            ohs = ovld & ordy;
            if (ohs) begin
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_extra_beat: cycle %0d odat=%h with nothing expected", c, odat);
                end else begin
                    if ({oidx, olast, odat} !== q[0]) begin
                        n_fail++;
                        $display("FAIL rand_beat: cycle %0d {oidx,olast,odat}=%h expected %h", c, {oidx, olast, odat}, q[0]);
                    end
                    void'(q.pop_front());
                end
                if (olast) olast_cnt++;
            end
            if (ihs) begin
                for (int j = 0; j < 4; j++) q.push_back({2'(j), ilast && (j == 3), idat[j*8 +: 8]});
                if (ilast) ilast_cnt++;
            end
            accepted = ihs;
            @(posedge clk);
            #1;
        end
        ivld = 1'b0; ordy = 1'b1;
        for (int c = 0; c < 16; c++) begin
            #1;
            if (ovld) begin
                n_tests++;
                if (q.size() == 0 || {oidx, olast, odat} !== q[0]) begin
                    n_fail++;
                    $display("FAIL rand_drain: {oidx,olast,odat}=%h queue size %0d", {oidx, olast, odat}, q.size());
                end
                if (q.size() != 0) void'(q.pop_front());
                if (olast) olast_cnt++;
            end
            @(posedge clk);
            #1;
        end
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_leftover: %0d beats never emitted, expected 0", q.size());
        end
        n_tests++;
        if (olast_cnt != ilast_cnt) begin
            n_fail++;
            $display("FAIL rand_last_count: olast count %0d expected %0d", olast_cnt, ilast_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_msb_first();
        test_reset_mid_word();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
